// File: rtl/counter_pkg.sv
// Shared encodings for param_counter: counting modes and direction values.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_SAT    = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Enabled-cycle prescaler: asserts tick on the enabled cycle where the
// internal count equals presc, then restarts from zero. presc=0 ticks on
// every enabled cycle. clr restarts the count and suppresses the tick.
module tick_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en && !clr && (cnt == presc);

  // Count enabled cycles; clear on tick or on an external restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/param_counter.sv
// Bounded up/down counter with SAT, WRAP and (optionally) BOUNCE modes,
// a tick prescaler, synchronous load and a one-cycle terminal-count pulse.
// Optional feature macro: PARAM_COUNTER_BOUNCE_EN compiles in BOUNCE mode;
// without it mode 2'b10 behaves as SAT.
module param_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int MAX_VAL = 32,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               sel,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   out,
  output logic               dir,
  output logic               at_max,
  output logic               at_min,
  output logic               tc
);

  localparam logic [WIDTH-1:0] MAX    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX_VAL - 1);

  logic             tick;
  logic             bounce;
  logic             wrap;
  logic             go_down;
  logic [WIDTH-1:0] nxt;
  logic             nxt_tc;
  logic             nxt_dir;
  logic [WIDTH-1:0] load_clamped;

  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clr     (load),
    .presc   (presc),
    .tick    (tick)
  );

  assign at_max       = (out == MAX);
  assign at_min       = (out == '0);
  assign load_clamped = (load_val > MAX) ? MAX : load_val;
  assign wrap         = (mode == MODE_WRAP);

  // Next count, terminal-count condition and direction for a tick step.
  always_comb begin
    bounce  = 1'b0;
    go_down = sel;
    nxt     = out;
    nxt_tc  = 1'b0;
    nxt_dir = sel;
`ifdef PARAM_COUNTER_BOUNCE_EN
    if (mode == MODE_BOUNCE) begin
      bounce = 1'b1;
      // Sitting on a bound always moves away from it, whatever dir says.
      if (out >= MAX)      go_down = DIR_DOWN;
      else if (out == '0)  go_down = DIR_UP;
      else                 go_down = dir;
    end
`endif
    if (go_down == DIR_UP) begin
      if (out >= MAX) begin
        if (wrap) begin
          nxt    = '0;
          nxt_tc = 1'b1;
        end
      end else begin
        nxt    = out + WIDTH'(1);
        nxt_tc = (out == MAX_M1);
      end
    end else begin
      if (out == '0) begin
        if (wrap) begin
          nxt    = MAX;
          nxt_tc = 1'b1;
        end
      end else begin
        nxt    = out - WIDTH'(1);
        nxt_tc = (out == WIDTH'(1));
      end
    end
    if (bounce) begin
      if (nxt >= MAX)      nxt_dir = DIR_DOWN;
      else if (nxt == '0)  nxt_dir = DIR_UP;
      else                 nxt_dir = go_down;
    end
  end

  // Count, direction and terminal-count registers; load beats enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
      dir <= DIR_UP;
      tc  <= 1'b0;
    end else if (load) begin
      out <= load_clamped;
      dir <= sel;
      tc  <= 1'b0;
    end else if (en) begin
      tc <= tick & nxt_tc;
      if (tick) out <= nxt;
      // In BOUNCE the direction only changes when a step actually happens.
      if (tick || !bounce) dir <= nxt_dir;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_param_counter;

  localparam int WIDTH   = 6;
  localparam int MAX_VAL = 32;
  localparam int PRESC_W = 4;
`ifdef PARAM_COUNTER_BOUNCE_EN
  localparam bit HAS_BOUNCE = 1'b1;
`else
  localparam bit HAS_BOUNCE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               en;
  logic               sel;
  logic [1:0]         mode;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   out;
  logic               dir;
  logic               at_max;
  logic               at_min;
  logic               tc;

  int vectors = 0;
  int miscompares = 0;

  // Reference state.
  int m_out, m_dir, m_tc, m_pc;
  int tc_count;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .mode(mode),
    .load(load), .load_val(load_val), .presc(presc), .out(out), .dir(dir),
    .at_max(at_max), .at_min(at_min), .tc(tc)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, int'(out), m_out);
    chk({tag, ".dir"}, int'(dir), m_dir);
    chk({tag, ".tc"}, int'(tc), m_tc);
    chk({tag, ".at_max"}, int'(at_max), (m_out == MAX_VAL) ? 1 : 0);
    chk({tag, ".at_min"}, int'(at_min), (m_out == 0) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_tc = 0; m_pc = 0;
  endtask

  // One rising edge of the specified behaviour, using the current inputs.
  task automatic model_edge();
    int  step;
    bit  ticked, bnc;
    if (!reset_n) begin
      model_reset();
    end else if (load) begin
      m_out = (int'(load_val) < MAX_VAL) ? int'(load_val) : MAX_VAL;
      m_pc  = 0;
      m_dir = int'(sel);
      m_tc  = 0;
    end else if (en) begin
      ticked = (m_pc == int'(presc));
      m_pc   = ticked ? 0 : (m_pc + 1) % (1 << PRESC_W);
      m_tc   = 0;
      bnc    = HAS_BOUNCE && (mode == 2'b10);
      if (!bnc) m_dir = int'(sel);
      if (ticked) begin
        if (bnc) begin
          if (m_out == MAX_VAL) step = -1;
          else if (m_out == 0)  step = 1;
          else                  step = (m_dir == 1) ? -1 : 1;
          m_out = m_out + step;
          if (m_out == MAX_VAL)  m_dir = 1;
          else if (m_out == 0)   m_dir = 0;
          else                   m_dir = (step < 0) ? 1 : 0;
          m_tc = ((step > 0 && m_out == MAX_VAL) || (step < 0 && m_out == 0)) ? 1 : 0;
        end else begin
          step = sel ? -1 : 1;
          if (m_out + step > MAX_VAL) begin
            if (mode == 2'b01) begin m_out = 0; m_tc = 1; end
          end else if (m_out + step < 0) begin
            if (mode == 2'b01) begin m_out = MAX_VAL; m_tc = 1; end
          end else begin
            m_out = m_out + step;
            m_tc  = ((step > 0 && m_out == MAX_VAL) || (step < 0 && m_out == 0)) ? 1 : 0;
          end
        end
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
    if (tc) tc_count++;
  endtask

  initial begin
    int prev;
    reset_n = 1'b0; en = 1'b0; sel = 1'b0; mode = 2'b00;
    load = 1'b0; load_val = '0; presc = '0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Saturating count up from zero.
    en = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 34; i++) cyc("sat_up");
    chk("sat_up.final", int'(out), 32);
    chk("sat_up.tc_pulses", tc_count, 1);

    // Saturating count down, with a frozen stretch in the middle.
    sel = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 10; i++) cyc("sat_dn");
    en = 1'b0;
    prev = int'(out);
    for (int i = 0; i < 3; i++) cyc("sat_dn_hold");
    chk("sat_dn.frozen", int'(out), prev);
    en = 1'b1;
    for (int i = 0; i < 25; i++) cyc("sat_dn");
    chk("sat_dn.final", int'(out), 0);
    chk("sat_dn.tc_pulses", tc_count, 1);

    // Wrap across the upper bound.
    mode = 2'b01; sel = 1'b0; load = 1'b1; load_val = 6'd30;
    cyc("wrap_load");
    chk("wrap.loaded", int'(out), 30);
    load = 1'b0;
    tc_count = 0;
    for (int i = 0; i < 4; i++) cyc("wrap");
    chk("wrap.final", int'(out), 1);
    chk("wrap.tc_pulses", tc_count, 2);

    // Bounce off the upper bound (or saturate when not compiled in).
    mode = 2'b10; load = 1'b1; load_val = 6'd31;
    cyc("bounce_load");
    load = 1'b0;
    for (int i = 0; i < 3; i++) cyc("bounce");
    chk("bounce.final", int'(out), HAS_BOUNCE ? 30 : 32);

    // Prescaled counting and a clamped load.
    mode = 2'b00; sel = 1'b0; presc = 4'd3; load = 1'b1; load_val = 6'd2;
    cyc("presc_load");
    load = 1'b0;
    for (int i = 0; i < 12; i++) cyc("presc");
    chk("presc.after12", int'(out), 5);
    load = 1'b1; load_val = 6'd50;
    cyc("clamp_load");
    chk("clamp.out", int'(out), 32);
    load = 1'b0;

    // Asynchronous reset between edges mid-count.
    mode = 2'b01; sel = 1'b1; presc = 4'd0;
    for (int i = 0; i < 5; i++) cyc("pre_areset");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("areset");
    cyc("areset_hold");
    @(negedge clk);
    reset_n = 1'b1;
    cyc("post_release");
    chk("post_release.out", int'(out), MAX_VAL);

    // Randomized run.
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      sel      = 1'($urandom);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) presc = 4'($urandom_range(0, 3));
      load     = ($urandom_range(0, 24) == 0);
      load_val = 6'($urandom);
      reset_n  = ($urandom_range(0, 199) != 0);
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 6: counter width in bits.
REQ-002 Parameter MAX_VAL, default 32: upper count bound; must satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
REQ-003 Parameter PRESC_W, default 4: prescaler width in bits.
REQ-004 Port clk, input, 1: single clock; all state is on the rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, 1: count enable; when low, count and prescaler hold.
REQ-007 Port sel, input, 1: requested direction; 0 = up, 1 = down.
REQ-008 Port mode, input, 2: 00 SAT, 01 WRAP, 10 BOUNCE, 11 treated as SAT.
REQ-009 Port load, input, 1: synchronous load strobe.
REQ-010 Port load_val, input, WIDTH: load value.
REQ-011 Port presc, input, PRESC_W: the count steps once every presc+1 enabled cycles.
REQ-012 Port out, output, WIDTH: registered count.
REQ-013 Port dir, output, 1: registered effective direction; 0 = up, 1 = down.
REQ-014 Port at_max / at_min, output, 1 each: combinational flags for out==MAX_VAL and out==0.
REQ-015 Port tc, output, 1: registered one-cycle terminal-count pulse.

Function
REQ-016 Priority is reset_n low, then load, then en; otherwise all state holds.
REQ-017 On load, out <= min(load_val, MAX_VAL), the prescaler clears, dir <= sel, and tc <= 0, regardless of en.
REQ-018 The prescaler counts enabled cycles; a tick is produced on the enabled cycle where prescaler==presc, then the prescaler returns to 0. With presc=0, every enabled cycle ticks.
REQ-019 A step updates out at the clock edge of the tick cycle, so latency from en sampled high with presc=0 is one edge.
REQ-020 SAT mode: up increments and holds at MAX_VAL; down decrements and holds at 0; dir <= sel every cycle.
REQ-021 WRAP mode: up from MAX_VAL goes to 0; down from 0 goes to MAX_VAL; dir <= sel every cycle.
REQ-022 BOUNCE mode: sel is ignored and dir drives the step. A step landing on MAX_VAL sets dir=1; a step landing on 0 sets dir=0. This gives the sequence ..., MAX-1, MAX, MAX-1, ....
REQ-023 On entry to BOUNCE at a bound, the first tick moves away from that bound.
REQ-024 tc is 1 for exactly the cycle after the edge on which a tick step makes out equal the bound in the direction of travel (MAX up, 0 down), including a WRAP wrap to 0 or MAX.
REQ-025 A SAT tick that holds at a bound does not assert tc.
REQ-026 A mode or presc change mid-count takes effect on the next cycle; out is not modified by the change.
REQ-027 All arithmetic is WIDTH bits with explicit bound compares; no unintended modulo 2^WIDTH overflow.

Reset
REQ-028 While reset_n is low: out=0, dir=0, tc=0, prescaler=0, asynchronously.
REQ-029 Reset deassertion is synchronous to clk; the first step can occur on the first enabled edge after release.
REQ-030 Reset asserted mid-count clears all state immediately; no pending tick survives.

Configuration
REQ-031 Macro PARAM_COUNTER_BOUNCE_EN, when defined, compiles in BOUNCE mode and the dir-reversal logic.
REQ-032 When PARAM_COUNTER_BOUNCE_EN is undefined, mode 10 behaves as SAT and dir always equals the registered sel.

Structure
REQ-033 Shared package counter_pkg holds the mode encoding constants (MODE_SAT, MODE_WRAP, MODE_BOUNCE) and the direction constants (DIR_UP, DIR_DOWN).
REQ-034 Sub-module tick_prescaler (PRESC_W, clk, reset_n, en, clr, presc, tick) implements REQ-018.

Verification
REQ-035 Reset, then en=1, sel=0, mode=SAT, presc=0 for 34 cycles: out goes 1..32 then holds at 32; tc pulses once after reaching 32.
REQ-036 From out=32, set sel=1: out goes 31..0 then holds at 0; tc pulses once after reaching 0; en=0 mid-sequence freezes out.
REQ-037 mode=WRAP, load_val=30, sel=0: out goes 30, 31, 32, 0, 1; tc pulses after 32 and after 0.
REQ-038 mode=BOUNCE (macro defined), load 31: out goes 32, 31, 30 with dir 1 after 32; without the macro the same stimulus holds at 32.
REQ-039 presc=3, en=1: out steps every 4th cycle; load=1 with load_val=50 gives out=32 and clears the prescaler.
REQ-040 reset_n low asynchronously between edges mid-count: out, dir and tc read 0 before the next clk edge.
